// File: rtl/note_pkg.sv
// Shared definitions for the buzzer note player: code constants, half-period
// table lookup, FSM states and octave mode encodings.
package note_pkg;

  localparam logic [7:0] CODE_REST = 8'd0;
  localparam logic [7:0] CODE_LOW  = 8'd11;
  localparam logic [7:0] CODE_MID  = 8'd21;
  localparam logic [7:0] CODE_HIGH = 8'd31;

  localparam int unsigned TBL_W = 12;
  localparam int unsigned HP_W  = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TONE = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OCT_NONE     = 2'b00,
    OCT_UP       = 2'b01,
    OCT_DOWN     = 2'b10,
    OCT_NONE_ALT = 2'b11
  } octave_t;

  typedef struct packed {
    logic             valid;
    logic [TBL_W-1:0] hp;
  } hp_entry_t;

  // Rest is a valid code with a zero half-period; unknown codes come back invalid.
  function automatic hp_entry_t hp_of(input logic [7:0] code);
    hp_entry_t e;
    e.valid = 1'b1;
    case (code)
      8'd0:    e.hp = 12'd0;
      8'd11:   e.hp = 12'd3822;
      8'd12:   e.hp = 12'd3405;
      8'd13:   e.hp = 12'd3034;
      8'd14:   e.hp = 12'd2864;
      8'd15:   e.hp = 12'd2551;
      8'd16:   e.hp = 12'd2273;
      8'd17:   e.hp = 12'd2025;
      8'd21:   e.hp = 12'd1911;
      8'd22:   e.hp = 12'd1703;
      8'd23:   e.hp = 12'd1517;
      8'd24:   e.hp = 12'd1432;
      8'd25:   e.hp = 12'd1276;
      8'd26:   e.hp = 12'd1136;
      8'd27:   e.hp = 12'd1012;
      8'd31:   e.hp = 12'd956;
      8'd32:   e.hp = 12'd851;
      8'd33:   e.hp = 12'd758;
      8'd34:   e.hp = 12'd716;
      8'd35:   e.hp = 12'd638;
      8'd36:   e.hp = 12'd568;
      8'd37:   e.hp = 12'd506;
      default: begin
        e.valid = 1'b0;
        e.hp    = '0;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Half-period divider: counts 1..hp while running and flips its toggle output
// each time the count reaches hp. Clear zeroes count and phase; idle holds both.
module tone_div
  import note_pkg::*;
#(
  parameter int unsigned CNT_W = HP_W
) (
  input  logic             clk_1M,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic             i_silent,
  input  logic [CNT_W-1:0] i_hp,
  output logic             o_tog
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tog;

  always_comb begin
    w_cnt_nxt = (r_cnt == i_hp) ? CNT_W'(1) : r_cnt + 1'b1;
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_tog <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_tog <= 1'b0;
    end else if (i_run) begin
      r_cnt <= w_cnt_nxt;
      if ((w_cnt_nxt == i_hp) && !i_silent) begin
        r_tog <= ~r_tog;
      end
    end
  end

  assign o_tog = r_tog;

endmodule

// File: rtl/note_player.sv
// Single-voice note player: accepts code/duration/octave over valid/ready,
// plays a square wave for the note length, then a fixed silent gap.
module note_player
  import note_pkg::*;
#(
  parameter int unsigned BEAT_CYC = 62500,
  parameter int unsigned GAP_CYC  = 2000,
  parameter int unsigned DUR_W    = 4
) (
  input  logic             clk_1M,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [7:0]       note_code,
  input  logic [DUR_W-1:0] note_dur,
  input  logic [1:0]       octave,
  output logic             beep,
  output logic             busy,
  output logic             bad_note
);

  localparam int unsigned TL_W = $clog2((2**DUR_W - 1) * BEAT_CYC + 1);
  localparam int unsigned GP_W = $clog2(GAP_CYC + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_code;
  logic [DUR_W-1:0]  r_dur;
  octave_t           r_oct;
  logic [HP_W-1:0]   r_hp;
  logic              r_silent;
  logic [TL_W-1:0]   r_tone_left;
  logic [GP_W-1:0]   r_gap_left;
  logic              r_alive;

  hp_entry_t         w_entry;
  logic [HP_W-1:0]   w_hp_base;
  logic [HP_W-1:0]   w_hp_load;
  logic              w_silent_load;
  logic [TL_W-1:0]   w_tone_len;
  logic              w_accept;
  logic              w_tog;

  // note_ready stays low through reset and until the first clock after release.
  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  assign note_ready = r_alive && enable && (r_state == ST_IDLE);
  assign w_accept   = note_valid && note_ready;
  assign busy       = (r_state != ST_IDLE);
  assign bad_note   = (r_state == ST_LOAD) && enable && !w_entry.valid;
  assign beep       = w_tog && enable && (r_state == ST_TONE);

  always_comb begin
    w_entry   = hp_of(r_code);
    w_hp_base = {1'b0, w_entry.hp};
    case (r_oct)
      OCT_UP:   w_hp_load = w_hp_base >> 1;
      OCT_DOWN: w_hp_load = w_hp_base << 1;
      default:  w_hp_load = w_hp_base;
    endcase
    w_silent_load = !w_entry.valid || (w_entry.hp == '0);
    w_tone_len    = TL_W'(r_dur) * TL_W'(BEAT_CYC) - TL_W'(GAP_CYC);
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (enable) begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = ST_LOAD;
        ST_LOAD: w_state_nxt = ST_TONE;
        ST_TONE: if (r_tone_left == TL_W'(1)) w_state_nxt = ST_GAP;
        ST_GAP:  if (r_gap_left == GP_W'(1)) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      r_code      <= '0;
      r_dur       <= '0;
      r_oct       <= OCT_NONE;
      r_hp        <= '0;
      r_silent    <= 1'b0;
      r_tone_left <= '0;
      r_gap_left  <= '0;
    end else if (enable) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_code <= note_code;
            r_dur  <= (note_dur == '0) ? DUR_W'(1) : note_dur;
            r_oct  <= octave_t'(octave);
          end
        end
        ST_LOAD: begin
          r_hp        <= w_hp_load;
          r_silent    <= w_silent_load;
          r_tone_left <= w_tone_len;
        end
        ST_TONE: begin
          r_tone_left <= r_tone_left - 1'b1;
          if (r_tone_left == TL_W'(1)) r_gap_left <= GP_W'(GAP_CYC);
        end
        ST_GAP: begin
          r_gap_left <= r_gap_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

  tone_div #(
    .CNT_W(HP_W)
  ) u_tone_div (
    .clk_1M  (clk_1M),
    .rst_n   (rst_n),
    .i_clr   (enable && (r_state == ST_LOAD)),
    .i_run   (enable && (r_state == ST_TONE)),
    .i_silent(r_silent),
    .i_hp    (r_hp),
    .o_tog   (w_tog)
  );

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: expected beep edges, ready-return time and bad_note
// pulses are queued from a reference model when each note is offered.
`timescale 1ns/1ps
module tb_note_player;

  localparam int BEAT = 4000;
  localparam int GAP  = 100;
  localparam int DW   = 4;

  logic          clk_1M = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          note_valid = 1'b0;
  logic [7:0]    note_code = '0;
  logic [DW-1:0] note_dur = '0;
  logic [1:0]    octave = '0;
  logic          note_ready, beep, busy, bad_note;

  typedef struct {
    int   t;
    logic lvl;
  } ev_t;

  ev_t exp_q[$];
  int  exp_ready_t;
  int  exp_bad;
  int  checks = 0;
  int  failures = 0;

  always #5 clk_1M = ~clk_1M;

  note_player #(
    .BEAT_CYC(BEAT),
    .GAP_CYC (GAP),
    .DUR_W   (DW)
  ) dut (
    .clk_1M    (clk_1M),
    .rst_n     (rst_n),
    .enable    (enable),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_code (note_code),
    .note_dur  (note_dur),
    .octave    (octave),
    .beep      (beep),
    .busy      (busy),
    .bad_note  (bad_note)
  );

  function automatic int tbl_hp(input int code);
    case (code)
      0:  return 0;
      11: return 3822; 12: return 3405; 13: return 3034; 14: return 2864;
      15: return 2551; 16: return 2273; 17: return 2025;
      21: return 1911; 22: return 1703; 23: return 1517; 24: return 1432;
      25: return 1276; 26: return 1136; 27: return 1012;
      31: return 956;  32: return 851;  33: return 758;  34: return 716;
      35: return 638;  36: return 568;  37: return 506;
      default: return -1;
    endcase
  endfunction

  // Times are in clocks after the accepting edge; TONE is first sampled at t=1.
  task automatic build_expect(input int code, input int dur, input int oct,
                              input int p, input int l);
    ev_t  nat[$];
    ev_t  e;
    int   dd, tl, base, hp;
    logic lvl;
    exp_q.delete();
    dd      = (dur == 0) ? 1 : dur;
    tl      = dd * BEAT - GAP;
    base    = tbl_hp(code);
    exp_bad = (base < 0) ? 1 : 0;
    hp      = (oct == 1) ? base / 2 : (oct == 2) ? base * 2 : base;
    lvl     = 1'b0;
    if (base > 0) begin
      for (int m = 1; m * hp < tl; m++) begin
        lvl = ~lvl;
        e.t = 1 + m * hp; e.lvl = lvl; nat.push_back(e);
      end
    end
    if (lvl) begin
      e.t = 1 + tl; e.lvl = 1'b0; nat.push_back(e);
    end
    exp_ready_t = 1 + tl + GAP;
    if (p < 0) begin
      exp_q = nat;
    end else begin
      lvl = 1'b0;
      foreach (nat[i]) if (nat[i].t <= p) begin
        exp_q.push_back(nat[i]); lvl = nat[i].lvl;
      end
      if (lvl) begin
        e.t = p + 1;     e.lvl = 1'b0; exp_q.push_back(e);
        e.t = p + l + 1; e.lvl = 1'b1; exp_q.push_back(e);
      end
      foreach (nat[i]) if (nat[i].t > p) begin
        e = nat[i]; e.t = e.t + l; exp_q.push_back(e);
      end
      if (exp_ready_t > p) exp_ready_t = exp_ready_t + l;
    end
  endtask

  task automatic accept_note(input int code, input int dur, input int oct);
    int w = 0;
    @(negedge clk_1M);
    while (note_ready !== 1'b1 && w < 200) begin
      @(negedge clk_1M);
      w++;
    end
    checks++;
    if (note_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait: note_ready=%b after %0d cycles, required 1", note_ready, w);
    end
    note_code  = 8'(code);
    note_dur   = DW'(dur);
    octave     = 2'(oct);
    note_valid = 1'b1;
    @(posedge clk_1M);
  endtask

  // Called right after the accepting edge; runs until note_ready returns.
  task automatic check_note(input string name, input int code, input int dur,
                            input int oct, input int p, input int l,
                            input bit hold, input logic [7:0] next_code);
    int   t = 0;
    int   bad_cnt = 0, bad_t = -1, ready_t = -1, busy_bad = 0;
    logic prev = 1'b0;
    bit   done = 0;
    ev_t  e;
    build_expect(code, dur, oct, p, l);
    while (!done) begin
      @(negedge clk_1M);
      if (bad_note === 1'b1) begin bad_cnt++; bad_t = t; end
      if (beep !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s beep_edge: got level %b at t=%0d, required no edge", name, beep, t);
        end else begin
          e = exp_q.pop_front();
          if (e.t != t || e.lvl !== beep) begin
            failures++;
            $display("FAIL %s beep_edge: got level %b at t=%0d, required %b at t=%0d",
                     name, beep, t, e.lvl, e.t);
          end
        end
        prev = beep;
      end
      if (note_ready === 1'b1) begin
        ready_t = t; done = 1;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        if (t == 0) begin
          note_code = hold ? next_code : 8'd99;
          if (!hold) note_valid = 1'b0;
        end
        if (p >= 0 && t == p)     enable = 1'b0;
        if (p >= 0 && t == p + l) enable = 1'b1;
        if (t > 30000) done = 1;
      end
      t++;
    end
    checks++;
    if (ready_t != exp_ready_t) begin
      failures++;
      $display("FAIL %s ready_time: got t=%0d, required t=%0d", name, ready_t, exp_ready_t);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_edges: got %0d outstanding, required 0 (next t=%0d)",
               name, exp_q.size(), exp_q[0].t);
    end
    checks++;
    if (bad_cnt != exp_bad || (exp_bad == 1 && bad_t != 0)) begin
      failures++;
      $display("FAIL %s bad_note: got %0d pulses (last t=%0d), required %0d at t=0",
               name, bad_cnt, bad_t, exp_bad);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s busy: got %0d low cycles while playing, required 0", name, busy_bad);
    end
  endtask

  task automatic test_reset;
    #22;
    checks++;
    if ({beep, note_ready, busy, bad_note} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got beep/ready/busy/bad=%b, required 0000",
               {beep, note_ready, busy, bad_note});
    end
    @(negedge clk_1M);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_1M);
    checks++;
    if ({beep, note_ready, busy, bad_note} !== 4'b0100) begin
      failures++;
      $display("FAIL idle_outputs: got beep/ready/busy/bad=%b, required 0100",
               {beep, note_ready, busy, bad_note});
    end
    enable = 1'b0;
    #1;
    checks++;
    if (note_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_paused: got %b, required 0", note_ready);
    end
    enable = 1'b1;
  endtask

  task automatic test_mid_do;
    accept_note(21, 1, 0);
    check_note("mid_do", 21, 1, 0, -1, 0, 1'b0, 8'd0);
  endtask

  task automatic test_octave;
    accept_note(21, 1, 1);
    check_note("oct_up", 21, 1, 1, -1, 0, 1'b0, 8'd0);
    accept_note(21, 1, 2);
    check_note("oct_down", 21, 1, 2, -1, 0, 1'b0, 8'd0);
  endtask

  task automatic test_rest_invalid;
    accept_note(0, 2, 0);
    check_note("rest", 0, 2, 0, -1, 0, 1'b0, 8'd0);
    accept_note(18, 1, 0);
    check_note("invalid", 18, 1, 0, -1, 0, 1'b0, 8'd0);
  endtask

  task automatic test_zero_dur;
    accept_note(22, 0, 0);
    check_note("zero_dur", 22, 0, 0, -1, 0, 1'b0, 8'd0);
  endtask

  task automatic test_pause;
    accept_note(21, 1, 1);
    check_note("pause", 21, 1, 1, 1001, 500, 1'b0, 8'd0);
  endtask

  task automatic test_reset_mid;
    accept_note(21, 1, 1);
    @(negedge clk_1M);
    note_valid = 1'b0;
    repeat (1499) @(negedge clk_1M);
    checks++;
    if (beep !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_beep: got %b, required 1", beep);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({beep, busy, note_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid: got beep/busy/ready=%b, required 000", {beep, busy, note_ready});
    end
    repeat (3) @(negedge clk_1M);
    rst_n = 1'b1;
    accept_note(23, 1, 0);
    check_note("after_reset", 23, 1, 0, -1, 0, 1'b0, 8'd0);
  endtask

  task automatic test_back_to_back;
    accept_note(21, 1, 0);
    check_note("b2b_first", 21, 1, 0, -1, 0, 1'b1, 8'd31);
    @(posedge clk_1M);
    check_note("b2b_second", 31, 1, 0, -1, 0, 1'b0, 8'd0);
  endtask

  initial begin
    test_reset;
    test_mid_do;
    test_octave;
    test_rest_invalid;
    test_zero_dur;
    test_pause;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
